reaction_round_ctrl: RTL and testbench
======================================

Name: reaction_round_ctrl

Overview:
Sequencer for the reaction-timer datapath: LED countdown, LFSR random delay, millisecond reaction count, best-time tracking.
Runs a multi-round game of 2**ROUNDS_LOG2 rounds and detects false starts.
Runs on the 50 MHz clock; all timing advances on the 1 ms tick enable.
Outputs feed LEDR, the LFSR enable and the bin2bcd/7-seg display path.

Parameters:
LED_STEP_MS, 500, ms between successive countdown LEDs
MIN_DELAY_MS, 1000, lower clamp on random delay
MAX_COUNT, 9999, reaction count saturation/timeout value
ROUNDS_LOG2, 2, log2 of rounds per game (4 rounds)

Ports:
clk  input  1  50 MHz system clock
rst_n  input  1  reset, asynchronous, active-low
tick_ms  input  1  one-clk pulse every 1 ms
start  input  1  start button, active-high level; rising edge detected internally
stop  input  1  response button, active-high level
rand_delay  input  14  LFSR value, ms
en_lfsr  output  1  LFSR free-run enable
ledr  output  10  LED bank
count  output  16  current/last reaction time, ms
best  output  16  best reaction time this game, ms
round  output  ROUNDS_LOG2+1  completed valid rounds
false_start  output  1  foul flag
done  output  1  game complete
avg  output  16  mean reaction time (see Optional Feature)

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low.
- Reset values: state=IDLE, ledr=0, count=0, best=MAX_COUNT, round=0, false_start=0, done=0, en_lfsr=1, avg=0, internal timers=0.
- start edge: registered previous-value detector; an edge is acted on only in IDLE, FOUL or DONE, and ignored elsewhere.
- Timers change only on cycles with tick_ms=1. stop is sampled every clk.
- States:
  - IDLE:
    - start edge -> COUNTDOWN; ledr=0, count=0, step timer=0.
  - COUNTDOWN:
    - every LED_STEP_MS ticks, ledr <= {ledr[8:0],1'b1}.
    - the step after ledr==10'h3FF -> WAIT; total duration 11*LED_STEP_MS ticks.
    - on the transition cycle, latch delay = max(rand_delay, MIN_DELAY_MS).
  - WAIT:
    - en_lfsr=0 (LFSR frozen); en_lfsr=1 in all other states.
    - delay decrements per tick. On the tick where delay reaches 0 -> MEASURE; ledr=0, count=0.
  - MEASURE:
    - count+1 per tick.
    - stop=1 -> RESULT.
    - count reaching MAX_COUNT -> RESULT (timeout, count holds MAX_COUNT).
  - RESULT (single cycle):
    - best <= min(best, count); round <= round+1.
    - if the new round == 2**ROUNDS_LOG2 -> DONE with done=1; else -> IDLE.
  - FOUL:
    - entered when stop=1 in COUNTDOWN or WAIT.
    - false_start=1, ledr=10'h2AA; count, best and round unchanged.
    - start edge -> COUNTDOWN, clears false_start.
  - DONE:
    - outputs held.
    - start edge -> COUNTDOWN; clears done, round, count, best (=MAX_COUNT) and the avg accumulator.
- Simultaneous events:
  - stop beats WAIT expiry (-> FOUL).
  - In MEASURE, stop+tick in one cycle: no increment, count is the pre-tick value.
  - stop already high on entry to COUNTDOWN -> FOUL on the next clk.
- Width: count is 16-bit, saturating; never wraps.
- Reset mid-operation: immediate return to reset values in any state.

Optional Feature:
Macro REACTION_AVERAGE_EN.
- Defined:
  - accumulator of width 16+ROUNDS_LOG2 adds count in each RESULT and clears on a new game.
  - on entry to DONE, avg <= sum >> ROUNDS_LOG2 (truncating).
  - avg holds until the next game starts, then resets to 0.
- Undefined: no accumulator; avg tied to 0.

Test Plan:
Common bench setup: LED_STEP_MS=2, MIN_DELAY_MS=5, MAX_COUNT=50, tick_ms every 4 clks.
1. Basic round: start edge, rand_delay=20.
   -> ledr fills 1 bit per 2 ticks, WAIT after 22 ticks, 20-tick delay, ledr=0.
   -> stop after 37 ticks: count=37, best=37, round=1, state IDLE.
2. Delay clamp: rand_delay=3 -> WAIT lasts exactly 5 ticks; en_lfsr=0 throughout WAIT.
3. False start: stop pulsed after 3 LEDs lit -> false_start=1, ledr=10'h2AA, round=0, count unchanged.
   -> next start edge clears false_start and restarts COUNTDOWN.
4. Timeout: no stop in MEASURE -> count=50, RESULT, best=50, round=1.
5. Full game: reaction times 30, 20, 40, 25 -> best=20, round=4, done=1.
   -> with REACTION_AVERAGE_EN, avg=28 (115>>2); without, avg=0.
6. Reset mid-MEASURE (count=12): rst_n low for 1 clk -> all outputs at reset values asynchronously, state IDLE.

Source files
------------

// File: rtl/reaction_round_ctrl.sv
// Round sequencer for the reaction timer: LED countdown, random wait, ms reaction count, best time.
// Optional running average of a full game is enabled by defining REACTION_AVERAGE_EN.
module reaction_round_ctrl #(
    parameter int LED_STEP_MS  = 500,
    parameter int MIN_DELAY_MS = 1000,
    parameter int MAX_COUNT    = 9999,
    parameter int ROUNDS_LOG2  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick_ms,
    input  logic                   start,
    input  logic                   stop,
    input  logic [13:0]            rand_delay,
    output logic                   en_lfsr,
    output logic [9:0]             ledr,
    output logic [15:0]            count,
    output logic [15:0]            best,
    output logic [ROUNDS_LOG2:0]   round,
    output logic                   false_start,
    output logic                   done,
    output logic [15:0]            avg
);

    // state     | meaning
    // IDLE      | waiting for start between rounds
    // COUNTDOWN | lighting LEDs one per LED_STEP_MS
    // WAIT      | random delay running, LFSR frozen
    // MEASURE   | counting ms until stop or timeout
    // RESULT    | one cycle: update best/round/average
    // FOUL      | stop pressed too early, waiting for start
    // DONE      | game over, results held until start
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_WAIT      = 3'd2,
        S_MEASURE   = 3'd3,
        S_RESULT    = 3'd4,
        S_FOUL      = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam int                RW           = ROUNDS_LOG2 + 1;
    localparam logic [15:0]       STEP_LAST    = 16'(LED_STEP_MS - 1);
    localparam logic [15:0]       MAX_CNT      = 16'(MAX_COUNT);
    localparam logic [13:0]       MIN_DLY      = 14'(MIN_DELAY_MS);
    localparam logic [RW-1:0]     ROUNDS_TOTAL = RW'(1 << ROUNDS_LOG2);

    state_t          r_state;
    logic            r_start_d;
    logic [15:0]     r_step_tmr;
    logic [13:0]     r_delay;
    logic [9:0]      r_ledr;
    logic [15:0]     r_count;
    logic [15:0]     r_best;
    logic [RW-1:0]   r_round;
    logic            r_false_start;
    logic            r_done;
    logic            r_en_lfsr;

    logic            w_start_edge;
    logic            w_go;
    logic            w_new_game;
    logic            w_last_round;
    logic [13:0]     w_delay_clamped;
    logic [15:0]     w_best_next;
    logic [RW-1:0]   w_round_next;

    assign w_start_edge    = start & ~r_start_d;
    // start is only honoured while parked; a press during a running round is ignored
    assign w_go            = w_start_edge &&
                             (r_state == S_IDLE || r_state == S_FOUL || r_state == S_DONE);
    assign w_new_game      = w_go && (r_state == S_DONE);
    assign w_round_next    = r_round + RW'(1);
    assign w_last_round    = (w_round_next == ROUNDS_TOTAL);
    assign w_delay_clamped = (rand_delay < MIN_DLY) ? MIN_DLY : rand_delay;
    assign w_best_next     = (r_count < r_best) ? r_count : r_best;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_start_d     <= 1'b0;
            r_step_tmr    <= '0;
            r_delay       <= '0;
            r_ledr        <= '0;
            r_count       <= '0;
            r_best        <= MAX_CNT;
            r_round       <= '0;
            r_false_start <= 1'b0;
            r_done        <= 1'b0;
            r_en_lfsr     <= 1'b1;
        end else begin
            r_start_d <= start;
            if (w_go) begin
                r_state       <= S_COUNTDOWN;
                r_ledr        <= '0;
                r_count       <= '0;
                r_step_tmr    <= '0;
                r_false_start <= 1'b0;
                r_en_lfsr     <= 1'b1;
                if (w_new_game) begin
                    r_done  <= 1'b0;
                    r_round <= '0;
                    r_best  <= MAX_CNT;
                end
            end else begin
                case (r_state)
                    S_COUNTDOWN: begin
                        if (stop) begin
                            r_state       <= S_FOUL;
                            r_false_start <= 1'b1;
                            r_ledr        <= 10'h2AA;
                        end else if (tick_ms) begin
                            if (r_step_tmr == STEP_LAST) begin
                                r_step_tmr <= '0;
                                // one extra step with all LEDs lit before the random wait begins
                                if (r_ledr == 10'h3FF) begin
                                    r_state   <= S_WAIT;
                                    r_delay   <= w_delay_clamped;
                                    r_en_lfsr <= 1'b0;
                                end else begin
                                    r_ledr <= {r_ledr[8:0], 1'b1};
                                end
                            end else begin
                                r_step_tmr <= r_step_tmr + 16'd1;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (stop) begin
                            r_state       <= S_FOUL;
                            r_false_start <= 1'b1;
                            r_ledr        <= 10'h2AA;
                            r_en_lfsr     <= 1'b1;
                        end else if (tick_ms) begin
                            if (r_delay <= 14'd1) begin
                                r_delay   <= '0;
                                r_state   <= S_MEASURE;
                                r_ledr    <= '0;
                                r_count   <= '0;
                                r_en_lfsr <= 1'b1;
                            end else begin
                                r_delay <= r_delay - 14'd1;
                            end
                        end
                    end
                    S_MEASURE: begin
                        if (stop) begin
                            r_state <= S_RESULT;
                        end else if (tick_ms) begin
                            if (r_count >= MAX_CNT - 16'd1) begin
                                r_count <= MAX_CNT;
                                r_state <= S_RESULT;
                            end else begin
                                r_count <= r_count + 16'd1;
                            end
                        end
                    end
                    S_RESULT: begin
                        r_best  <= w_best_next;
                        r_round <= w_round_next;
                        if (w_last_round) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_IDLE, S_FOUL, S_DONE: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef REACTION_AVERAGE_EN
    localparam int ACC_W = 16 + ROUNDS_LOG2;

    logic [ACC_W-1:0] r_acc;
    logic [15:0]      r_avg;
    logic [ACC_W-1:0] w_acc_next;

    assign w_acc_next = r_acc + ACC_W'(r_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_avg <= '0;
        end else if (w_new_game) begin
            r_acc <= '0;
            r_avg <= '0;
        end else if (r_state == S_RESULT) begin
            r_acc <= w_acc_next;
            if (w_last_round) begin
                r_avg <= 16'(w_acc_next >> ROUNDS_LOG2);
            end
        end
    end

    assign avg = r_avg;
`else
    assign avg = '0;
`endif

    assign en_lfsr     = r_en_lfsr;
    assign ledr        = r_ledr;
    assign count       = r_count;
    assign best        = r_best;
    assign round       = r_round;
    assign false_start = r_false_start;
    assign done        = r_done;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl with small timing parameters and a tick every 4 clocks.
module tb_reaction_round_ctrl;

    localparam int RL2 = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick_ms = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [13:0]   rand_delay = 14'd20;
    logic          en_lfsr;
    logic [9:0]    ledr;
    logic [15:0]   count;
    logic [15:0]   best;
    logic [RL2:0]  round;
    logic          false_start;
    logic          done;
    logic [15:0]   avg;

    int errors = 0;
    int checks = 0;

    reaction_round_ctrl #(
        .LED_STEP_MS (2),
        .MIN_DELAY_MS(5),
        .MAX_COUNT   (50),
        .ROUNDS_LOG2 (RL2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_ms    (tick_ms),
        .start      (start),
        .stop       (stop),
        .rand_delay (rand_delay),
        .en_lfsr    (en_lfsr),
        .ledr       (ledr),
        .count      (count),
        .best       (best),
        .round      (round),
        .false_start(false_start),
        .done       (done),
        .avg        (avg)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            tick_ms = 1'b1;
            @(negedge clk);
            tick_ms = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (tick_ms !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic press_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // stop is raised so that it lands on the same clock edge as a tick
    task automatic stop_on_tick();
        do begin
            @(negedge clk);
            #1;
        end while (tick_ms !== 1'b1);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    task automatic to_measure(input logic [13:0] d, input int wait_ticks);
        rand_delay = d;
        press_start();
        tick_n(22);
        tick_n(wait_ticks);
    endtask

    task automatic play_round(input int rt);
        to_measure(14'd7, 7);
        tick_n(rt);
        stop_on_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ledr, count, best, round, false_start, done, en_lfsr, avg} !==
            {10'h000, 16'd0, 16'd50, 3'd0, 1'b0, 1'b0, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL reset_vals: ledr=%h count=%0d best=%0d round=%0d fs=%b done=%b en=%b avg=%0d expected 000/0/50/0/0/0/1/0",
                     ledr, count, best, round, false_start, done, en_lfsr, avg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick_n(3);
        checks++;
        if (ledr !== 10'h000 || count !== 16'd0 || en_lfsr !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: ledr=%h count=%0d en=%b expected 000/0/1", ledr, count, en_lfsr);
        end
    endtask

    task automatic test_basic_round();
        int e;
        do_reset();
        rand_delay = 14'd20;
        press_start();
        for (int k = 1; k <= 21; k++) begin
            tick_n(1);
            e = (1 << (k / 2)) - 1;
            checks++;
            if (ledr !== e[9:0] || en_lfsr !== 1'b1) begin
                errors++;
                $display("FAIL basic_led_tick%0d: ledr=%h en=%b expected %h en=1", k, ledr, en_lfsr, e[9:0]);
            end
        end
        tick_n(1);
        checks++;
        if (en_lfsr !== 1'b0 || ledr !== 10'h3FF) begin
            errors++;
            $display("FAIL basic_wait_entry: en=%b ledr=%h expected 0/3ff", en_lfsr, ledr);
        end
        tick_n(19);
        checks++;
        if (en_lfsr !== 1'b0 || ledr !== 10'h3FF) begin
            errors++;
            $display("FAIL basic_wait_19: en=%b ledr=%h expected 0/3ff", en_lfsr, ledr);
        end
        tick_n(1);
        checks++;
        if (en_lfsr !== 1'b1 || ledr !== 10'h000 || count !== 16'd0) begin
            errors++;
            $display("FAIL basic_measure_entry: en=%b ledr=%h count=%0d expected 1/000/0", en_lfsr, ledr, count);
        end
        tick_n(37);
        checks++;
        if (count !== 16'd37) begin
            errors++;
            $display("FAIL basic_count37: count=%0d expected 37", count);
        end
        stop_on_tick();
        @(posedge clk);
        #1;
        checks++;
        if (count !== 16'd37 || best !== 16'd37 || round !== 3'd1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: count=%0d best=%0d round=%0d done=%b expected 37/37/1/0",
                     count, best, round, done);
        end
        tick_n(4);
        checks++;
        if (count !== 16'd37 || ledr !== 10'h000) begin
            errors++;
            $display("FAIL basic_idle_hold: count=%0d ledr=%h expected 37/000", count, ledr);
        end
    endtask

    task automatic test_delay_clamp();
        do_reset();
        rand_delay = 14'd3;
        press_start();
        tick_n(22);
        for (int k = 1; k <= 4; k++) begin
            tick_n(1);
            checks++;
            if (en_lfsr !== 1'b0 || ledr !== 10'h3FF) begin
                errors++;
                $display("FAIL clamp_wait%0d: en=%b ledr=%h expected 0/3ff", k, en_lfsr, ledr);
            end
        end
        tick_n(1);
        checks++;
        if (en_lfsr !== 1'b1 || ledr !== 10'h000) begin
            errors++;
            $display("FAIL clamp_expire: en=%b ledr=%h expected 1/000", en_lfsr, ledr);
        end
        stop_on_tick();
        @(posedge clk);
        #1;
        checks++;
        if (count !== 16'd0 || best !== 16'd0 || round !== 3'd1) begin
            errors++;
            $display("FAIL clamp_zero_rt: count=%0d best=%0d round=%0d expected 0/0/1", count, best, round);
        end
    endtask

    task automatic test_false_start();
        do_reset();
        rand_delay = 14'd20;
        press_start();
        tick_n(6);
        checks++;
        if (ledr !== 10'h007) begin
            errors++;
            $display("FAIL fs_three_leds: ledr=%h expected 007", ledr);
        end
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        checks++;
        if (false_start !== 1'b1 || ledr !== 10'h2AA || round !== 3'd0 || count !== 16'd0) begin
            errors++;
            $display("FAIL fs_foul: fs=%b ledr=%h round=%0d count=%0d expected 1/2aa/0/0",
                     false_start, ledr, round, count);
        end
        @(negedge clk);
        stop  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (false_start !== 1'b0 || ledr !== 10'h000) begin
            errors++;
            $display("FAIL fs_restart: fs=%b ledr=%h expected 0/000", false_start, ledr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (false_start !== 1'b1 || ledr !== 10'h2AA) begin
            errors++;
            $display("FAIL fs_stop_on_entry: fs=%b ledr=%h expected 1/2aa", false_start, ledr);
        end
        @(negedge clk);
        stop  = 1'b0;
        start = 1'b0;
        press_start();
        tick_n(2);
        checks++;
        if (false_start !== 1'b0 || ledr !== 10'h001) begin
            errors++;
            $display("FAIL fs_clean_restart: fs=%b ledr=%h expected 0/001", false_start, ledr);
        end
    endtask

    task automatic test_wait_race();
        do_reset();
        rand_delay = 14'd3;
        press_start();
        tick_n(22);
        tick_n(4);
        stop_on_tick();
        checks++;
        if (false_start !== 1'b1 || ledr !== 10'h2AA || en_lfsr !== 1'b1) begin
            errors++;
            $display("FAIL race_stop_wins: fs=%b ledr=%h en=%b expected 1/2aa/1", false_start, ledr, en_lfsr);
        end
        tick_n(3);
        checks++;
        if (count !== 16'd0 || round !== 3'd0) begin
            errors++;
            $display("FAIL race_no_measure: count=%0d round=%0d expected 0/0", count, round);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        to_measure(14'd5, 5);
        tick_n(49);
        checks++;
        if (count !== 16'd49) begin
            errors++;
            $display("FAIL timeout_49: count=%0d expected 49", count);
        end
        tick_n(1);
        checks++;
        if (count !== 16'd50) begin
            errors++;
            $display("FAIL timeout_50: count=%0d expected 50", count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (best !== 16'd50 || round !== 3'd1) begin
            errors++;
            $display("FAIL timeout_result: best=%0d round=%0d expected 50/1", best, round);
        end
        tick_n(4);
        checks++;
        if (count !== 16'd50) begin
            errors++;
            $display("FAIL timeout_saturate: count=%0d expected 50", count);
        end
    endtask

    task automatic test_full_game();
        logic [15:0] exp_avg;
        int rts [4];
`ifdef REACTION_AVERAGE_EN
        exp_avg = 16'd28;
`else
        exp_avg = 16'd0;
`endif
        rts = '{30, 20, 40, 25};
        do_reset();
        for (int r = 0; r < 3; r++) begin
            play_round(rts[r]);
            checks++;
            if (round !== 3'(r + 1) || done !== 1'b0 || count !== 16'(rts[r])) begin
                errors++;
                $display("FAIL game_round%0d: round=%0d done=%b count=%0d expected %0d/0/%0d",
                         r + 1, round, done, count, r + 1, rts[r]);
            end
        end
        play_round(rts[3]);
        checks++;
        if (round !== 3'd4 || done !== 1'b1 || best !== 16'd20 || count !== 16'd25) begin
            errors++;
            $display("FAIL game_done: round=%0d done=%b best=%0d count=%0d expected 4/1/20/25",
                     round, done, best, count);
        end
        checks++;
        if (avg !== exp_avg) begin
            errors++;
            $display("FAIL game_avg: avg=%0d expected %0d", avg, exp_avg);
        end
        tick_n(4);
        checks++;
        if (done !== 1'b1 || count !== 16'd25 || avg !== exp_avg) begin
            errors++;
            $display("FAIL game_hold: done=%b count=%0d avg=%0d expected 1/25/%0d", done, count, avg, exp_avg);
        end
        press_start();
        checks++;
        if (done !== 1'b0 || round !== 3'd0 || best !== 16'd50 || count !== 16'd0 || avg !== 16'd0) begin
            errors++;
            $display("FAIL game_new: done=%b round=%0d best=%0d count=%0d avg=%0d expected 0/0/50/0/0",
                     done, round, best, count, avg);
        end
    endtask

    task automatic test_reset_mid_measure();
        do_reset();
        play_round(30);
        to_measure(14'd7, 7);
        tick_n(12);
        checks++;
        if (count !== 16'd12 || round !== 3'd1 || best !== 16'd30) begin
            errors++;
            $display("FAIL midrst_pre: count=%0d round=%0d best=%0d expected 12/1/30", count, round, best);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ledr, count, best, round, false_start, done, en_lfsr, avg} !==
            {10'h000, 16'd0, 16'd50, 3'd0, 1'b0, 1'b0, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL midrst_async: ledr=%h count=%0d best=%0d round=%0d fs=%b done=%b en=%b avg=%0d",
                     ledr, count, best, round, false_start, done, en_lfsr, avg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        press_start();
        tick_n(2);
        checks++;
        if (ledr !== 10'h001 || count !== 16'd0) begin
            errors++;
            $display("FAIL midrst_idle: ledr=%h count=%0d expected 001/0", ledr, count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_round();
        test_delay_clamp();
        test_false_start();
        test_wait_race();
        test_timeout();
        test_full_game();
        test_reset_mid_measure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
